// File: rtl/hdmi_palette_lut.sv
// Writable RGB palette for the HDMI pixel path: initialisation sweep, per-entry blink,
// global dimming and a two-stage lookup pipeline.
module hdmi_palette_lut #(
   parameter int IDX_W      = 4,
   parameter int COLOR_W    = 8,
   parameter int BLINK_HALF = 50_000_000
) (
   input  logic                 clk_100MHz,
   input  logic                 Reset,
   input  logic                 pix_valid_in,
   input  logic [IDX_W-1:0]     pix_idx,
   input  logic [1:0]           dim_shift,
   input  logic                 cfg_wr_valid,
   output logic                 cfg_wr_ready,
   input  logic [IDX_W-1:0]     cfg_wr_idx,
   input  logic [3*COLOR_W-1:0] cfg_wr_rgb,
   input  logic                 cfg_wr_blink,
   output logic                 pix_valid_out,
   output logic [COLOR_W-1:0]   ROM_Red,
   output logic [COLOR_W-1:0]   ROM_Green,
   output logic [COLOR_W-1:0]   ROM_Blue,
   output logic                 blink_phase,
   output logic                 init_busy
);

   localparam int DEPTH = 2**IDX_W;
   localparam int RGB_W = 3*COLOR_W;
   localparam int CNT_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_init_ptr;
   logic                 r_cfg_wr_ready;
   logic                 r_init_busy;

   // Entry layout: {blink, R, G, B}
   logic [RGB_W:0]       r_mem [DEPTH];

   logic                 w_mem_we;
   logic [IDX_W-1:0]     w_mem_idx;
   logic [RGB_W:0]       w_mem_data;

   logic [CNT_W-1:0]     r_blink_cnt;
   logic                 r_blink_phase;

   logic                 r_s1_valid;
   logic [RGB_W:0]       r_s1_entry;
   logic                 r_s2_valid;
   logic [COLOR_W-1:0]   r_red;
   logic [COLOR_W-1:0]   r_green;
   logic [COLOR_W-1:0]   r_blue;

   logic [RGB_W-1:0]     w_rgb;
   logic [COLOR_W-1:0]   w_red;
   logic [COLOR_W-1:0]   w_green;
   logic [COLOR_W-1:0]   w_blue;

   always_ff @(posedge clk_100MHz or posedge Reset) begin
      if (Reset) begin
         r_state        <= ST_INIT;
         r_init_ptr     <= '0;
         r_cfg_wr_ready <= 1'b0;
         r_init_busy    <= 1'b1;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_init_ptr <= r_init_ptr + 1'b1;
               if (r_init_ptr == '1) begin
                  r_state        <= ST_IDLE;
                  r_cfg_wr_ready <= 1'b1;
                  r_init_busy    <= 1'b0;
               end
            end
            default: begin
               r_cfg_wr_ready <= 1'b1;
               r_init_busy    <= 1'b0;
            end
         endcase
      end
   end

   // The sweep owns the write port during INIT; configuration writes only when ready
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_idx  = cfg_wr_idx;
      w_mem_data = {cfg_wr_blink, cfg_wr_rgb};
      if (r_state == ST_INIT) begin
         w_mem_we   = 1'b1;
         w_mem_idx  = r_init_ptr;
         w_mem_data = (r_init_ptr == IDX_W'(1)) ? {1'b0, {RGB_W{1'b1}}} : '0;
      end else if (cfg_wr_valid && r_cfg_wr_ready) begin
         w_mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (w_mem_we)
         r_mem[w_mem_idx] <= w_mem_data;
   end

   always_ff @(posedge clk_100MHz or posedge Reset) begin
      if (Reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   always_comb begin
      w_rgb   = (r_s1_entry[RGB_W] && r_blink_phase) ? '0 : r_s1_entry[RGB_W-1:0];
      w_red   = w_rgb[RGB_W-1 -: COLOR_W] >> dim_shift;
      w_green = w_rgb[2*COLOR_W-1 -: COLOR_W] >> dim_shift;
      w_blue  = w_rgb[COLOR_W-1:0] >> dim_shift;
   end

   always_ff @(posedge clk_100MHz or posedge Reset) begin
      if (Reset) begin
         r_s1_valid <= 1'b0;
         r_s1_entry <= '0;
         r_s2_valid <= 1'b0;
         r_red      <= '0;
         r_green    <= '0;
         r_blue     <= '0;
      end else begin
         r_s1_valid <= pix_valid_in;
         r_s1_entry <= r_mem[pix_idx];
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid && (r_state == ST_IDLE)) begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
         end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
         end
      end
   end

   assign cfg_wr_ready  = r_cfg_wr_ready;
   assign init_busy     = r_init_busy;
   assign blink_phase   = r_blink_phase;
   assign pix_valid_out = r_s2_valid;
   assign ROM_Red       = r_red;
   assign ROM_Green     = r_green;
   assign ROM_Blue      = r_blue;

endmodule

// File: tb/tb_hdmi_palette_lut.sv
// Scoreboard bench for hdmi_palette_lut: randomized and directed traffic against a
// cycle-indexed reference model of the palette, blink timing and init sweep.
module tb_hdmi_palette_lut;

   localparam int IDX_W   = 4;
   localparam int COLOR_W = 8;
   localparam int BH      = 4;
   localparam int DEPTH   = 16;

   logic                 clk_100MHz;
   logic                 Reset;
   logic                 pix_valid_in;
   logic [IDX_W-1:0]     pix_idx;
   logic [1:0]           dim_shift;
   logic                 cfg_wr_valid;
   logic                 cfg_wr_ready;
   logic [IDX_W-1:0]     cfg_wr_idx;
   logic [3*COLOR_W-1:0] cfg_wr_rgb;
   logic                 cfg_wr_blink;
   logic                 pix_valid_out;
   logic [COLOR_W-1:0]   ROM_Red;
   logic [COLOR_W-1:0]   ROM_Green;
   logic [COLOR_W-1:0]   ROM_Blue;
   logic                 blink_phase;
   logic                 init_busy;

   hdmi_palette_lut #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .BLINK_HALF(BH)) dut (
      .clk_100MHz   (clk_100MHz),
      .Reset        (Reset),
      .pix_valid_in (pix_valid_in),
      .pix_idx      (pix_idx),
      .dim_shift    (dim_shift),
      .cfg_wr_valid (cfg_wr_valid),
      .cfg_wr_ready (cfg_wr_ready),
      .cfg_wr_idx   (cfg_wr_idx),
      .cfg_wr_rgb   (cfg_wr_rgb),
      .cfg_wr_blink (cfg_wr_blink),
      .pix_valid_out(pix_valid_out),
      .ROM_Red      (ROM_Red),
      .ROM_Green    (ROM_Green),
      .ROM_Blue     (ROM_Blue),
      .blink_phase  (blink_phase),
      .init_busy    (init_busy)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   // Edges seen since Reset was released
   int n = 0;
   always @(posedge clk_100MHz) n = Reset ? 0 : n + 1;

   logic [23:0] m_rgb   [DEPTH];
   bit          m_blink [DEPTH];
   int          dim = 0;
   logic [23:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   function automatic logic [23:0] dimmed(input logic [23:0] c, input int d);
      logic [7:0] r, g, b;
      r = c[23:16] >> d;
      g = c[15:8] >> d;
      b = c[7:0] >> d;
      return {r, g, b};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_rgb[i]   = (i == 1) ? 24'hFFFFFF : 24'h000000;
         m_blink[i] = 1'b0;
      end
      exp_q.delete();
   endtask

   // Drive one cycle; the lookup sees the palette before this cycle's write
   task automatic cyc(input bit v, input int idx, input bit wv, input int widx,
                      input logic [23:0] rgb, input bit bl);
      if (n == DEPTH - 1) v = 1'b0;
      pix_valid_in = v;
      pix_idx      = idx[IDX_W-1:0];
      cfg_wr_valid = wv;
      cfg_wr_idx   = widx[IDX_W-1:0];
      cfg_wr_rgb   = rgb;
      cfg_wr_blink = bl;
      if (v) begin
         if (n + 2 <= DEPTH)
            exp_q.push_back(24'h0);
         else if (m_blink[idx] && (((n + 1) / BH) % 2 == 1))
            exp_q.push_back(24'h0);
         else
            exp_q.push_back(dimmed(m_rgb[idx], dim));
      end
      if (wv && n >= DEPTH) begin
         m_rgb[widx]   = rgb;
         m_blink[widx] = bl;
      end
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cyc(0, 0, 0, 0, 24'h0, 0);
   endtask

   task automatic lookup(input int idx);
      cyc(1, idx, 0, 0, 24'h0, 0);
   endtask

   task automatic set_dim(input int d);
      idle(1);
      dim       = d;
      dim_shift = d[1:0];
   endtask

   task automatic rand_cyc();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
          $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1),
          24'($urandom), $urandom_range(0, 2) == 0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      model_reset();
      pix_valid_in = 1'b0;
      cfg_wr_valid = 1'b0;
      @(posedge clk_100MHz); #1;
      @(posedge clk_100MHz); #1;
      Reset = 1'b0;
   endtask

   always @(negedge clk_100MHz) begin
      if (Reset) begin
         chk(!pix_valid_out && {ROM_Red, ROM_Green, ROM_Blue} == 24'h0, "reset_outputs",
             {7'h0, pix_valid_out, ROM_Red, ROM_Green, ROM_Blue}, 32'h0);
         chk(init_busy && !cfg_wr_ready, "reset_flags", {init_busy, cfg_wr_ready}, 2'b10);
      end else begin
         chk(init_busy == (n < DEPTH), "init_busy", init_busy, n < DEPTH);
         chk(cfg_wr_ready == (n >= DEPTH), "cfg_wr_ready", cfg_wr_ready, n >= DEPTH);
         chk(blink_phase == ((n / BH) % 2), "blink_phase", blink_phase, (n / BH) % 2);
         if (pix_valid_out) begin
            if (exp_q.size() == 0) begin
               chk(0, "unexpected_valid", 1, 0);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               chk({ROM_Red, ROM_Green, ROM_Blue} == e, "pixel_rgb",
                   {ROM_Red, ROM_Green, ROM_Blue}, e);
            end
         end else begin
            chk({ROM_Red, ROM_Green, ROM_Blue} == 24'h0, "idle_rgb",
                {ROM_Red, ROM_Green, ROM_Blue}, 24'h0);
         end
      end
   end

   initial begin
      Reset        = 1'b1;
      pix_valid_in = 1'b0;
      pix_idx      = '0;
      dim_shift    = 2'd0;
      cfg_wr_valid = 1'b0;
      cfg_wr_idx   = '0;
      cfg_wr_rgb   = '0;
      cfg_wr_blink = 1'b0;
      do_reset();

      // Traffic during the init sweep: writes ignored, lookups read black
      for (int i = 0; i < DEPTH; i++) rand_cyc();
      idle(2);
      lookup(0);
      lookup(1);
      lookup(5);
      idle(3);

      cyc(0, 0, 1, 3, 24'h123456, 0);
      lookup(3);
      idle(2);

      cyc(1, 2, 1, 2, 24'hAABBCC, 0);
      lookup(2);
      idle(2);

      cyc(0, 0, 1, 4, 24'hFF0000, 1);
      for (int i = 0; i < 16; i++) lookup(4);
      for (int i = 0; i < 8; i++) lookup(1);
      for (int i = 0; i < 8; i++) lookup((i % 2 == 0) ? 4 : 1);

      set_dim(2);
      lookup(1);
      set_dim(0);
      lookup(1);
      idle(2);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) set_dim($urandom_range(0, 3));
         rand_cyc();
      end
      set_dim(0);

      cyc(0, 0, 1, 3, 24'h00FF00, 0);
      for (int i = 0; i < 5; i++) rand_cyc();
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) rand_cyc();
      lookup(3);
      lookup(1);
      for (int i = 0; i < 40; i++) rand_cyc();
      idle(4);

      chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
